// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges in-order pipe results and buffered long-latency results onto one RF write port.
// Optional macro WB_FWD_EN adds combinational fwd_* copies of the write selected this cycle.
module writeback_arbiter #(
  parameter int GPR_WIDTH = 32,
  parameter int RF_SIZE   = 16,
  parameter int LU_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_valid,
  input  logic [4:0]           pipe_rd,
  input  logic [GPR_WIDTH-1:0] pipe_data,
  input  logic                 lu_valid,
  input  logic [4:0]           lu_rd,
  input  logic [GPR_WIDTH-1:0] lu_data,
  output logic                 lu_ready,
  output logic                 rf_en,
  output logic [4:0]           rf_rd,
  output logic [GPR_WIDTH-1:0] rf_data,
  output logic [RF_SIZE-1:0]   lu_pending
`ifdef WB_FWD_EN
  ,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [GPR_WIDTH-1:0] fwd_data
`endif
);
  localparam int PTR_W = (LU_DEPTH > 1) ? $clog2(LU_DEPTH) : 1;
  localparam int CNT_W = $clog2(LU_DEPTH + 1);
  localparam logic [5:0] RF_LIM = 6'(RF_SIZE);

  logic [PTR_W-1:0]     r_rptr, r_wptr;
  logic [CNT_W-1:0]     r_cnt;
  logic [LU_DEPTH-1:0]  r_vld;
  logic [4:0]           r_q_rd   [LU_DEPTH];
  logic [GPR_WIDTH-1:0] r_q_data [LU_DEPTH];

  logic                 w_empty, w_full, w_acc, w_lu_ok, w_pipe_ok;
  logic                 w_push, w_pop, w_en;
  logic [4:0]           w_rd;
  logic [GPR_WIDTH-1:0] w_data;
  logic [RF_SIZE-1:0]   w_pend;

  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (32'(p) == LU_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_W'(LU_DEPTH));
  // Ready comes only from registered occupancy: a full FIFO refuses even while popping.
  assign lu_ready  = !w_full && !rst;
  assign w_acc     = lu_valid && lu_ready;
  assign w_lu_ok   = ({1'b0, lu_rd} < RF_LIM);
  assign w_pipe_ok = pipe_valid && ({1'b0, pipe_rd} < RF_LIM);

  assign w_pop  = !w_pipe_ok && !w_empty;
  // Out-of-range lu results are accepted and discarded; a bypassed one never enters the FIFO.
  assign w_push = w_acc && w_lu_ok && !(w_empty && !w_pipe_ok);

  always_comb begin
    w_en   = 1'b0;
    w_rd   = '0;
    w_data = '0;
    if (w_pipe_ok) begin
      w_en   = 1'b1;
      w_rd   = pipe_rd;
      w_data = pipe_data;
    end else if (!w_empty) begin
      w_en   = 1'b1;
      w_rd   = r_q_rd[r_rptr];
      w_data = r_q_data[r_rptr];
    end else if (w_acc && w_lu_ok) begin
      w_en   = 1'b1;
      w_rd   = lu_rd;
      w_data = lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= inc(r_rptr);
      end
      if (w_push) begin
        r_vld[r_wptr]    <= 1'b1;
        r_q_rd[r_wptr]   <= lu_rd;
        r_q_data[r_wptr] <= lu_data;
        r_wptr           <= inc(r_wptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < LU_DEPTH; i++)
      for (int j = 0; j < RF_SIZE; j++)
        if (r_vld[i] && (r_q_rd[i] == 5'(j))) w_pend[j] = 1'b1;
  end
  assign lu_pending = w_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_en   <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
    end else begin
      rf_en <= w_en;
      if (w_en) begin
        rf_rd   <= w_rd;
        rf_data <= w_data;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = w_en && !rst;
  assign fwd_rd    = w_rd;
  assign fwd_data  = w_data;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed vector table, reset sequences, randomized model-based phase.
module tb_writeback_arbiter;
  localparam int W = 32;

  logic        clk, rst;
  logic        pipe_valid, lu_valid, lu_ready, rf_en;
  logic [4:0]  pipe_rd, lu_rd, rf_rd;
  logic [W-1:0] pipe_data, lu_data, rf_data;
  logic [15:0] lu_pending;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [W-1:0] fwd_data;
`endif

  writeback_arbiter #(.GPR_WIDTH(W), .RF_SIZE(16), .LU_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data), .lu_pending(lu_pending)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic pv; logic [4:0] prd; logic [31:0] pd;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic rdy; logic [15:0] pend;
    logic en; logic [4:0] rd; logic [31:0] data;
  } vec_t;
  typedef struct { logic en; logic [4:0] rd; logic [31:0] data; } wr_t;

  int   n_chk = 0, n_fail = 0;
  wr_t  sb[$];
  wr_t  mq[$];
  vec_t vt[20];

  function automatic vec_t mk(logic pv, logic [4:0] prd, logic [31:0] pd,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic rdy, logic [15:0] pend,
                              logic en, logic [4:0] rd, logic [31:0] data);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.rdy = rdy; v.pend = pend; v.en = en; v.rd = rd; v.data = data;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] act=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle; ready/pending/fwd checked before the edge, rf outputs after it via the scoreboard.
  task automatic drive_chk(input vec_t v, input int idx);
    wr_t e;
    @(negedge clk);
    pipe_valid = v.pv; pipe_rd = v.prd; pipe_data = v.pd;
    lu_valid = v.lv; lu_rd = v.lrd; lu_data = v.ld;
    e.en = v.en; e.rd = v.rd; e.data = v.data;
    sb.push_back(e);
    #1;
    chk("lu_ready", idx, 32'(lu_ready), 32'(v.rdy));
    chk("lu_pending", idx, 32'(lu_pending), 32'(v.pend));
`ifdef WB_FWD_EN
    chk("fwd_valid", idx, 32'(fwd_valid), 32'(v.en));
    if (v.en) begin
      chk("fwd_rd", idx, 32'(fwd_rd), 32'(v.rd));
      chk("fwd_data", idx, fwd_data, v.data);
    end
`endif
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("rf_en", idx, 32'(rf_en), 32'(e.en));
    chk("rf_rd", idx, 32'(rf_rd), 32'(e.rd));
    chk("rf_data", idx, rf_data, e.data);
  endtask

  initial begin
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    vec_t v;
    wr_t  ent;
    logic acc, pok, lok, byp;

    //        pv prd  pdata          lv lrd  ldata      rdy pend     en rd  data
    vt[0]  = mk(1, 3,  32'hDEADBEEF, 0, 0,  32'h0,     1, 16'h0000, 1, 3,  32'hDEADBEEF);
    vt[1]  = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 16'h0000, 0, 3,  32'hDEADBEEF);
    vt[2]  = mk(1, 1,  32'h11,       1, 5,  32'h55,    1, 16'h0000, 1, 1,  32'h11);
    vt[3]  = mk(1, 2,  32'h22,       0, 0,  32'h0,     1, 16'h0020, 1, 2,  32'h22);
    vt[4]  = mk(1, 3,  32'h33,       0, 0,  32'h0,     1, 16'h0020, 1, 3,  32'h33);
    vt[5]  = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 16'h0020, 1, 5,  32'h55);
    vt[6]  = mk(1, 1,  32'h101,      1, 6,  32'h66,    1, 16'h0000, 1, 1,  32'h101);
    vt[7]  = mk(1, 2,  32'h102,      1, 7,  32'h77,    1, 16'h0040, 1, 2,  32'h102);
    vt[8]  = mk(1, 3,  32'h103,      1, 8,  32'h88,    0, 16'h00C0, 1, 3,  32'h103);
    vt[9]  = mk(0, 0,  32'h0,        1, 8,  32'h88,    0, 16'h00C0, 1, 6,  32'h66);
    vt[10] = mk(0, 0,  32'h0,        1, 8,  32'h88,    1, 16'h0080, 1, 7,  32'h77);
    vt[11] = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 16'h0100, 1, 8,  32'h88);
    vt[12] = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 16'h0000, 0, 8,  32'h88);
    vt[13] = mk(0, 0,  32'h0,        1, 9,  32'h1234,  1, 16'h0000, 1, 9,  32'h1234);
    vt[14] = mk(1, 20, 32'hBAD,      0, 0,  32'h0,     1, 16'h0000, 0, 9,  32'h1234);
    vt[15] = mk(0, 0,  32'h0,        1, 17, 32'h77,    1, 16'h0000, 0, 9,  32'h1234);
    vt[16] = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 16'h0000, 0, 9,  32'h1234);
    vt[17] = mk(1, 20, 32'hBAD,      1, 10, 32'hAA,    1, 16'h0000, 1, 10, 32'hAA);
    vt[18] = mk(1, 15, 32'hF0F0,     0, 0,  32'h0,     1, 16'h0000, 1, 15, 32'hF0F0);
    vt[19] = mk(0, 0,  32'h0,        0, 0,  32'h0,     1, 16'h0000, 0, 15, 32'hF0F0);

    rst = 1'b1; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h44;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst_rf_en", c, 32'(rf_en), 32'h0);
      chk("rst_rf_rd", c, 32'(rf_rd), 32'h0);
      chk("rst_rf_data", c, rf_data, 32'h0);
      chk("rst_lu_ready", c, 32'(lu_ready), 32'h0);
      chk("rst_pending", c, 32'(lu_pending), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0; lu_valid = 1'b0;

    for (int i = 0; i < 20; i++) drive_chk(vt[i], i);

    // Reset with a full FIFO must discard everything buffered.
    drive_chk(mk(1, 1, 32'h201, 1, 6, 32'h66, 1, 16'h0000, 1, 1, 32'h201), 100);
    drive_chk(mk(1, 2, 32'h202, 1, 7, 32'h77, 1, 16'h0040, 1, 2, 32'h202), 101);
    @(negedge clk);
    rst = 1'b1; pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h404; lu_valid = 1'b0;
    #1;
    chk("midrst_ready", 0, 32'(lu_ready), 32'h0);
    chk("midrst_pend_pre", 0, 32'(lu_pending), 32'h00C0);
    @(posedge clk); #1;
    chk("midrst_rf_en", 0, 32'(rf_en), 32'h0);
    chk("midrst_rf_rd", 0, 32'(rf_rd), 32'h0);
    chk("midrst_rf_data", 0, rf_data, 32'h0);
    chk("midrst_pend", 0, 32'(lu_pending), 32'h0);
    @(negedge clk);
    rst = 1'b0; pipe_valid = 1'b0;
    #1;
    chk("midrst_ready_rel", 0, 32'(lu_ready), 32'h1);
    @(posedge clk); #1;
    chk("midrst_no_drain", 0, 32'(rf_en), 32'h0);

    // Randomized phase against a queue-based reference model.
    m_rd = '0; m_data = '0;
    for (int i = 0; i < 300; i++) begin
      v.pv = 1'($urandom_range(0, 1)); v.prd = 5'($urandom_range(0, 23)); v.pd = $urandom;
      v.lv = 1'($urandom_range(0, 1)); v.lrd = 5'($urandom_range(0, 19)); v.ld = $urandom;
      v.rdy = (mq.size() < 2);
      v.pend = '0;
      foreach (mq[k]) v.pend[mq[k].rd[3:0]] = 1'b1;
      acc = v.lv && v.rdy;
      pok = v.pv && (v.prd < 5'd16);
      lok = (v.lrd < 5'd16);
      byp = 1'b0;
      v.en = 1'b1;
      if (pok) begin
        m_rd = v.prd; m_data = v.pd;
      end else if (mq.size() > 0) begin
        ent = mq.pop_front();
        m_rd = ent.rd; m_data = ent.data;
      end else if (acc && lok) begin
        m_rd = v.lrd; m_data = v.ld; byp = 1'b1;
      end else begin
        v.en = 1'b0;
      end
      if (acc && lok && !byp) begin
        ent.en = 1'b1; ent.rd = v.lrd; ent.data = v.ld;
        mq.push_back(ent);
      end
      v.rd = m_rd; v.data = m_data;
      drive_chk(v, 200 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
